regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-port controller for the 32x32 integer register file (x0 hardwired zero).
//  - Shares its single write port between NREQ writeback sources (ALU, LSU, MUL/DIV) using round-robin arbitration.
//  - Holds a pending-write scoreboard that the issue stage uses to detect RAW/WAW hazards.
//  - Drives the register-file write enable, destination register and write data from a registered output stage.
// PARAMETERS
//  NREQ   2   number of writeback requesters (2..4)
//  XLEN   32  data width
//  RAW    5   register index width (2**RAW registers)
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          reset; asynchronous assert, active-low
//  req_valid     in   NREQ       requester i has a writeback
//  req_ready     out  NREQ       requester i granted this cycle (one-hot or 0)
//  req_rd        in   NREQ*RAW   destination index, slice i
//  req_data      in   NREQ*XLEN  write data, slice i
//  alloc_valid   in   1          issue stage claims a destination
//  alloc_rd      in   RAW        claimed destination
//  alloc_ready   out  1          claim accepted (destination not already pending)
//  chk_rs1       in   RAW        issue-stage source 1
//  chk_rs2       in   RAW        issue-stage source 2
//  rs1_busy      out  1          source 1 has a pending write
//  rs2_busy      out  1          source 2 has a pending write
//  rf_w_enb      out  1          register-file write enable
//  rf_rd         out  RAW        register-file destination index
//  rf_w_data     out  XLEN       register-file write data
// BEHAVIOUR
//  - Reset (rst=0, asynchronous):
//    - pending[] cleared; round-robin pointer set to 0.
//    - rf_w_enb=0, rf_rd=0, rf_w_data=0.
//    - Any request in flight is dropped; requesters must re-present after reset.
//  - Arbitration (combinational):
//    - Winner is the first valid requester at or after ptr, scanning i=ptr..ptr+NREQ-1 mod NREQ.
//    - req_ready is asserted only for the winner. The output stage accepts every cycle, so there is no back-pressure.
//    - A transfer occurs when req_valid[i] and req_ready[i] are both high. On a transfer, ptr <= winner+1 mod NREQ. With no transfer, ptr holds.
//    - Requesters hold req_rd and req_data stable while valid and not granted.
//  - Output stage: latency 1 clock.
//    - Transfer with rd!=0: next cycle rf_w_enb=1, rf_rd=rd, rf_w_data=data.
//    - Transfer with rd==0: consumed, but rf_w_enb=0 next cycle (write discarded).
//    - No transfer: rf_w_enb=0; rf_rd and rf_w_data hold their previous values.
//  - Scoreboard pending[1:2**RAW-1]:
//    - Clear: pending[rd] is cleared on the cycle rf_w_enb=1 for that rd.
//    - Set: alloc_ready = (alloc_rd==0) | ~pending[alloc_rd].
//      - Accepted alloc with alloc_rd!=0 sets pending[alloc_rd].
//      - alloc_rd==0 is accepted and has no effect.
//    - Same-cycle set and clear of the same index: set wins, so the new producer is tracked.
//    - rsN_busy = (chk_rsN!=0) & pending[chk_rsN]; x0 is never busy.
//    - rsN_busy reflects the registered pending state. A write issued this cycle still reads busy unless bypass is enabled.
//  - Writeback to a non-pending index is legal: the write happens and the scoreboard is unchanged.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined:
//    - Adds outputs rs1_fwd_hit, rs2_fwd_hit (1 bit) and rs1_fwd_data, rs2_fwd_data (XLEN).
//    - rsN_fwd_hit = rf_w_enb & (rf_rd==chk_rsN) & (chk_rsN!=0).
//    - rsN_fwd_data = rf_w_data.
//    - rsN_busy is forced to 0 whenever rsN_fwd_hit=1.
//  RF_WB_BYPASS_EN undefined:
//    - No forwarding ports; busy is taken purely from pending[].
//    - The issue stage waits one extra cycle after the write.
// STRUCTURE
//  - Package rv_core_pkg holds XLEN=32, REG_AW=5, NUM_REGS=32 and REG_ZERO=5'd0. Parameters default from these.
//  - Sub-module rr_arbiter #(N): inputs req[N-1:0] and ptr, outputs a one-hot grant. Purely combinational.
//  - Pointer, scoreboard and output register live in regfile_wb_arbiter.
// TESTING
//  - Reset: drive rst=0 mid-transfer.
//    -> rf_w_enb=0 and all busy=0 immediately; ptr=0 after release.
//  - Single request: req0 rd=5, data=0xDEAD_BEEF.
//    -> req_ready[0]=1 the same cycle; next cycle rf_w_enb=1, rf_rd=5, rf_w_data=0xDEADBEEF.
//  - Fairness: req0 and req1 held valid for 6 cycles.
//    -> grants alternate 0,1,0,1,0,1; rf_w_enb=1 on every cycle after the first.
//  - Scoreboard: alloc rd=7, then chk_rs1=7, then writeback rd=7.
//    -> rs1_busy=1 until the cycle after rf_w_enb; a second alloc of rd=7 while pending gets alloc_ready=0.
//  - x0: alloc rd=0 and writeback rd=0 with data 0x1234.
//    -> alloc_ready=1, busy stays 0, rf_w_enb stays 0.
//  - Collision: alloc rd=3 in the same cycle rf_w_enb writes rd=3.
//    -> pending[3]=1 afterwards. With RF_WB_BYPASS_EN, rs1=3 in the write cycle gives fwd_hit=1 and busy=0.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Core-wide integer register file constants shared by writeback and issue logic.
package rv_core_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Scan ptr..ptr+N-1 modulo N; the first hit wins.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PW'((32'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin writeback arbitration, pending-write
// scoreboard and registered write stage. Optional forwarding under RF_WB_BYPASS_EN.
module regfile_wb_arbiter
    import rv_core_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned XLEN = rv_core_pkg::XLEN,
    parameter int unsigned RAW  = rv_core_pkg::REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*RAW-1:0]  req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 alloc_valid,
    input  logic [RAW-1:0]       alloc_rd,
    output logic                 alloc_ready,
    input  logic [RAW-1:0]       chk_rs1,
    input  logic [RAW-1:0]       chk_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
`ifdef RF_WB_BYPASS_EN
    output logic                 rs1_fwd_hit,
    output logic                 rs2_fwd_hit,
    output logic [XLEN-1:0]      rs1_fwd_data,
    output logic [XLEN-1:0]      rs2_fwd_data,
`endif
    output logic                 rf_w_enb,
    output logic [RAW-1:0]       rf_rd,
    output logic [XLEN-1:0]      rf_w_data
);

    localparam int unsigned    PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned    NREGS   = 2 ** RAW;
    localparam logic [RAW-1:0] RD_ZERO = RAW'(REG_ZERO);

    logic [PW-1:0]    r_ptr;
    logic [NREGS-1:0] r_pending;
    logic             r_w_enb;
    logic [RAW-1:0]   r_rd;
    logic [XLEN-1:0]  r_w_data;

    logic [NREQ-1:0]  w_grant;
    logic             w_xfer;
    logic [PW-1:0]    w_win;
    logic [RAW-1:0]   w_win_rd;
    logic [XLEN-1:0]  w_win_data;
    logic [PW-1:0]    w_ptr_nxt;
    logic             w_alloc_ok;
    logic [NREGS-1:0] w_pending_nxt;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    // Select the granted requester's payload.
    always_comb begin
        w_win      = '0;
        w_win_rd   = '0;
        w_win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win      = PW'(i);
                w_win_rd   = req_rd[i*RAW +: RAW];
                w_win_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

    assign w_alloc_ok  = (alloc_rd == RD_ZERO) | ~r_pending[alloc_rd];
    assign alloc_ready = w_alloc_ok;

    // Clear on the write, then set on a new claim so a same-cycle re-alloc stays tracked.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_w_enb) begin
            w_pending_nxt[r_rd] = 1'b0;
        end
        if (alloc_valid && w_alloc_ok && (alloc_rd != RD_ZERO)) begin
            w_pending_nxt[alloc_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd_hit  = r_w_enb & (r_rd == chk_rs1) & (chk_rs1 != RD_ZERO);
    assign rs2_fwd_hit  = r_w_enb & (r_rd == chk_rs2) & (chk_rs2 != RD_ZERO);
    assign rs1_fwd_data = r_w_data;
    assign rs2_fwd_data = r_w_data;
    assign rs1_busy     = (chk_rs1 != RD_ZERO) & r_pending[chk_rs1] & ~rs1_fwd_hit;
    assign rs2_busy     = (chk_rs2 != RD_ZERO) & r_pending[chk_rs2] & ~rs2_fwd_hit;
`else
    assign rs1_busy     = (chk_rs1 != RD_ZERO) & r_pending[chk_rs1];
    assign rs2_busy     = (chk_rs2 != RD_ZERO) & r_pending[chk_rs2];
`endif

    // Pointer, scoreboard and write stage; rd==0 transfers are consumed without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_pending <= '0;
            r_w_enb   <= 1'b0;
            r_rd      <= '0;
            r_w_data  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_w_enb   <= w_xfer & (w_win_rd != RD_ZERO);
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_xfer && (w_win_rd != RD_ZERO)) begin
                r_rd     <= w_win_rd;
                r_w_data <= w_win_data;
            end
        end
    end

    assign rf_w_enb  = r_w_enb;
    assign rf_rd     = r_rd;
    assign rf_w_data = r_w_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (NREQ=2): scenario tasks plus a write-stage scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [9:0]  req_rd = '0;
    logic [63:0] req_data = '0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic        alloc_ready;
    logic [4:0]  chk_rs1 = '0;
    logic [4:0]  chk_rs2 = '0;
    logic        rs1_busy, rs2_busy;
`ifdef RF_WB_BYPASS_EN
    logic        rs1_fwd_hit, rs2_fwd_hit;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif
    logic        rf_w_enb;
    logic [4:0]  rf_rd;
    logic [31:0] rf_w_data;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int errors = 0;
    int checks = 0;

    // Reference arbitration state
    int          m_ptr = 0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_wrd = '0;
    logic [31:0] m_wdata = '0;

    // Combinational outputs sampled mid-cycle
    logic [1:0]  s_ready;
    logic        s_aready, s_b1, s_b2, s_fwd1;

    regfile_wb_arbiter #(.NREQ(2), .XLEN(32), .RAW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
`ifdef RF_WB_BYPASS_EN
        .rs1_fwd_hit  (rs1_fwd_hit),
        .rs2_fwd_hit  (rs2_fwd_hit),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
`endif
        .rf_w_enb     (rf_w_enb),
        .rf_rd        (rf_rd),
        .rf_w_data    (rf_w_data)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, sample combinational outputs, push the expected write stage.
    task automatic run_cycle(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic av, input logic [4:0] ard,
                             input logic [4:0] c1, input logic [4:0] c2);
        int   w;
        exp_t x;
        @(negedge clk);
        req_valid   = v;
        req_rd      = {rd1, rd0};
        req_data    = {d1, d0};
        alloc_valid = av;
        alloc_rd    = ard;
        chk_rs1     = c1;
        chk_rs2     = c2;
        #1;
        s_ready  = req_ready;
        s_aready = alloc_ready;
        s_b1     = rs1_busy;
        s_b2     = rs2_busy;
`ifdef RF_WB_BYPASS_EN
        s_fwd1   = rs1_fwd_hit;
`else
        s_fwd1   = 1'b0;
`endif
        w = -1;
        for (int k = 0; k < 2; k++) begin
            if (w < 0 && v[(m_ptr + k) % 2]) w = (m_ptr + k) % 2;
        end
        if (w >= 0) begin
            m_ptr = (w + 1) % 2;
            m_wen = ((w == 0) ? rd0 : rd1) != 5'd0;
            if (m_wen) begin
                m_wrd   = (w == 0) ? rd0 : rd1;
                m_wdata = (w == 0) ? d0 : d1;
            end
        end else begin
            m_wen = 1'b0;
        end
        x.en = m_wen; x.rd = m_wrd; x.data = m_wdata;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        run_cycle(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, c1, c2);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rf_w_enb !== 1'b0) begin errors++; $display("FAIL reset_init_wen: got %b want 0", rf_w_enb); end
        checks++; if (rf_w_data !== 32'h0) begin errors++; $display("FAIL reset_init_data: got %h want 0", rf_w_data); end
        @(negedge clk); rst = 1'b1;
        run_cycle(2'b01, 5'd9, 5'd0, 32'hAAAA_0009, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL reset_pre_ready: got %b want 01", s_ready); end
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== e.en || rf_rd !== e.rd) begin
            errors++; $display("FAIL reset_pre_write: got en=%b rd=%0d want en=%b rd=%0d", rf_w_enb, rf_rd, e.en, e.rd); end
        // Assert reset mid-cycle while a write is being presented and rd 9 is pending
        rst = 1'b0; req_valid = 2'b00; alloc_valid = 1'b0;
        #1;
        checks++; if (rf_w_enb !== 1'b0) begin errors++; $display("FAIL reset_async_wen: got %b want 0", rf_w_enb); end
        checks++; if (rf_rd !== 5'd0 || rf_w_data !== 32'h0) begin
            errors++; $display("FAIL reset_async_out: got rd=%0d data=%h want 0/0", rf_rd, rf_w_data); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b want 0", rs1_busy); end
        m_ptr = 0; m_wen = 1'b0; m_wrd = '0; m_wdata = '0;
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        run_cycle(2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL reset_ptr_zero: got %b want 01", s_ready); end
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== 1'b1 || rf_rd !== 5'd1 || rf_w_data !== 32'h11) begin
            errors++; $display("FAIL reset_post_write: got en=%b rd=%0d data=%h want 1/1/11", rf_w_enb, rf_rd, rf_w_data); end
    endtask

    task automatic test_single;
        run_cycle(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", s_ready); end
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== e.en || rf_rd !== e.rd || rf_w_data !== e.data) begin
            errors++; $display("FAIL single_write: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h",
                               rf_w_enb, rf_rd, rf_w_data, e.en, e.rd, e.data); end
        idle(5'd0, 5'd0);
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== e.en) begin errors++; $display("FAIL single_idle_wen: got %b want %b", rf_w_enb, e.en); end
        checks++; if (rf_rd !== 5'd5 || rf_w_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_hold: got rd=%0d data=%h want 5/deadbeef", rf_rd, rf_w_data); end
    endtask

    task automatic test_fairness;
        logic [1:0] want;
        // Lone req1 moves the pointer back to requester 0
        run_cycle(2'b10, 5'd0, 5'd11, 32'h0, 32'hB000_0000, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (s_ready !== 2'b10) begin errors++; $display("FAIL fair_lone1: got %b want 10", s_ready); end
        e = exp_q.pop_front();
        for (int k = 0; k < 6; k++) begin
            run_cycle(2'b11, 5'd10, 5'd11, 32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k),
                      1'b0, 5'd0, 5'd0, 5'd0);
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (s_ready !== want) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, s_ready, want); end
            e = exp_q.pop_front();
            checks++; if (rf_w_enb !== e.en || rf_rd !== e.rd || rf_w_data !== e.data) begin
                errors++; $display("FAIL fair_write%0d: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h",
                                   k, rf_w_enb, rf_rd, rf_w_data, e.en, e.rd, e.data); end
        end
        idle(5'd0, 5'd0);
        e = exp_q.pop_front();
    endtask

    task automatic test_scoreboard;
        run_cycle(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
        checks++; if (s_aready !== 1'b1 || s_b1 !== 1'b0) begin
            errors++; $display("FAIL sb_alloc: got ready=%b busy=%b want 1/0", s_aready, s_b1); end
        e = exp_q.pop_front();
        run_cycle(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
        checks++; if (s_aready !== 1'b0) begin errors++; $display("FAIL sb_realloc: got %b want 0", s_aready); end
        checks++; if (s_b1 !== 1'b1 || s_b2 !== 1'b1) begin
            errors++; $display("FAIL sb_busy: got rs1=%b rs2=%b want 1/1", s_b1, s_b2); end
        e = exp_q.pop_front();
        run_cycle(2'b01, 5'd7, 5'd0, 32'h7777_7777, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        checks++; if (s_b1 !== 1'b1 || s_ready !== 2'b01) begin
            errors++; $display("FAIL sb_wb_issue: got busy=%b ready=%b want 1/01", s_b1, s_ready); end
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== e.en || rf_rd !== e.rd || rf_w_data !== e.data) begin
            errors++; $display("FAIL sb_write: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h",
                               rf_w_enb, rf_rd, rf_w_data, e.en, e.rd, e.data); end
        idle(5'd7, 5'd0);
`ifdef RF_WB_BYPASS_EN
        checks++; if (s_b1 !== 1'b0) begin errors++; $display("FAIL sb_busy_wcycle: got %b want 0", s_b1); end
`else
        checks++; if (s_b1 !== 1'b1) begin errors++; $display("FAIL sb_busy_wcycle: got %b want 1", s_b1); end
`endif
        e = exp_q.pop_front();
        idle(5'd7, 5'd0);
        checks++; if (s_b1 !== 1'b0) begin errors++; $display("FAIL sb_busy_cleared: got %b want 0", s_b1); end
        e = exp_q.pop_front();
    endtask

    task automatic test_x0;
        run_cycle(2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++; if (s_aready !== 1'b1 || s_ready !== 2'b01) begin
            errors++; $display("FAIL x0_accept: got aready=%b ready=%b want 1/01", s_aready, s_ready); end
        checks++; if (s_b1 !== 1'b0 || s_b2 !== 1'b0) begin
            errors++; $display("FAIL x0_busy: got %b/%b want 0/0", s_b1, s_b2); end
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== e.en) begin errors++; $display("FAIL x0_wen: got %b want %b", rf_w_enb, e.en); end
        idle(5'd0, 5'd0);
        checks++; if (s_b1 !== 1'b0) begin errors++; $display("FAIL x0_busy_after: got %b want 0", s_b1); end
        e = exp_q.pop_front();
    endtask

    task automatic test_collision;
        run_cycle(2'b01, 5'd3, 5'd0, 32'h3333_3333, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        e = exp_q.pop_front();
        checks++; if (rf_w_enb !== e.en || rf_rd !== e.rd) begin
            errors++; $display("FAIL col_write: got en=%b rd=%0d want en=%b rd=%0d", rf_w_enb, rf_rd, e.en, e.rd); end
        // Claim rd 3 in the cycle it is being written
        run_cycle(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        checks++; if (s_aready !== 1'b1 || s_b1 !== 1'b0) begin
            errors++; $display("FAIL col_alloc: got ready=%b busy=%b want 1/0", s_aready, s_b1); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (s_fwd1 !== 1'b1) begin errors++; $display("FAIL col_fwd_hit: got %b want 1", s_fwd1); end
`endif
        e = exp_q.pop_front();
        idle(5'd3, 5'd0);
        checks++; if (s_b1 !== 1'b1) begin errors++; $display("FAIL col_pending: got %b want 1", s_b1); end
        e = exp_q.pop_front();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_scoreboard();
        test_x0();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
